// File: rtl/ofifo.sv
// Output FIFO for a MAC array: one independent circular FIFO lane per column.
// Lanes fill on their own per-column strobes (skew tolerant) and are popped
// together as one full row once every lane holds at least one entry.
// The head of each lane is presented first-word-fall-through.
module ofifo #(
   parameter int col     = 8,
   parameter int psum_bw = 16,
   parameter int depth   = 64
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [psum_bw*col-1:0]   in,
   input  logic [col-1:0]           wr,
   input  logic                     rd,
   output logic [psum_bw*col-1:0]   out,
   output logic                     o_valid,
   output logic                     o_full,
   output logic                     o_ready,
   output logic                     o_overflow
);

   localparam int AW = $clog2(depth);
   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Storage is not reset; only the pointers define what is valid.
   logic [psum_bw-1:0] mem_q [col][depth];

   // Pointers carry one extra MSB to tell full from empty.
   logic [AW:0] wptr_q [col];
   logic [AW:0] wptr_d [col];
   logic [AW:0] rptr_q [col];
   logic [AW:0] rptr_d [col];

   logic overflow_q;
   logic overflow_d;

   logic [col-1:0] empty_s;
   logic [col-1:0] full_s;
   logic [col-1:0] push_s;
   logic [col-1:0] drop_s;
   logic           pop_s;

   // Per-lane status, pop/push qualification and pointer next-state.
   always_comb begin
      empty_s    = '0;
      full_s     = '0;
      push_s     = '0;
      drop_s     = '0;
      pop_s      = 1'b0;
      overflow_d = overflow_q;
      for (int i = 0; i < col; i++) begin
         wptr_d[i] = wptr_q[i];
         rptr_d[i] = rptr_q[i];
      end

      for (int i = 0; i < col; i++) begin
         empty_s[i] = (wptr_q[i] == rptr_q[i]);
         full_s[i]  = (wptr_q[i][AW-1:0] == rptr_q[i][AW-1:0]) &&
                      (wptr_q[i][AW] != rptr_q[i][AW]);
      end

      // A row can only be popped when every lane has an entry.
      pop_s = rd & (&(~empty_s));

      for (int i = 0; i < col; i++) begin
         // A simultaneous pop frees a slot in a full lane before the push lands.
         push_s[i] = wr[i] & (~full_s[i] | pop_s);
         drop_s[i] = wr[i] & full_s[i] & ~pop_s;
         if (push_s[i]) begin
            wptr_d[i] = wptr_q[i] + PTR_ONE;
         end else begin
            wptr_d[i] = wptr_q[i];
         end
         if (pop_s) begin
            rptr_d[i] = rptr_q[i] + PTR_ONE;
         end else begin
            rptr_d[i] = rptr_q[i];
         end
      end

      if (|drop_s) begin
         overflow_d = 1'b1;
      end else begin
         overflow_d = overflow_q;
      end
   end

   // Pointer and sticky-overflow registers, cleared asynchronously.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < col; i++) begin
            wptr_q[i] <= '0;
            rptr_q[i] <= '0;
         end
         overflow_q <= 1'b0;
      end else begin
         for (int i = 0; i < col; i++) begin
            wptr_q[i] <= wptr_d[i];
            rptr_q[i] <= rptr_d[i];
         end
         overflow_q <= overflow_d;
      end
   end

   // Entry storage: each accepted push writes its lane slice at the write pointer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < col; i++) begin
         if (push_s[i]) begin
            mem_q[i][wptr_q[i][AW-1:0]] <= in[psum_bw*i +: psum_bw];
         end
      end
   end

   // Head-of-lane fall-through data and combinational status flags.
   always_comb begin
      out = '0;
      for (int i = 0; i < col; i++) begin
         out[psum_bw*i +: psum_bw] = mem_q[i][rptr_q[i][AW-1:0]];
      end
      o_valid    = &(~empty_s);
      o_full     = |full_s;
      o_ready    = ~(|full_s);
      o_overflow = overflow_q;
   end

endmodule

// File: tb/tb_ofifo.sv
// Bench for ofifo: directed scenarios plus random traffic, checked against a
// queue-per-lane reference model.
module tb_ofifo;

   localparam int COL   = 8;
   localparam int W     = 16;
   localparam int DEPTH = 64;

   logic             clk;
   logic             reset;
   logic [W*COL-1:0] in;
   logic [COL-1:0]   wr;
   logic             rd;
   logic [W*COL-1:0] out;
   logic             o_valid;
   logic             o_full;
   logic             o_ready;
   logic             o_overflow;

   int total;
   int bad;

   // Reference model: one queue per lane plus the sticky overflow bit.
   logic [W-1:0] q [COL][$];
   logic         ovf_m;

   ofifo #(.col(COL), .psum_bw(W), .depth(DEPTH)) dut (
      .clk        (clk),
      .reset      (reset),
      .in         (in),
      .wr         (wr),
      .rd         (rd),
      .out        (out),
      .o_valid    (o_valid),
      .o_full     (o_full),
      .o_ready    (o_ready),
      .o_overflow (o_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic ev;
      logic ef;
      ev = 1'b1;
      ef = 1'b0;
      for (int i = 0; i < COL; i++) begin
         if (q[i].size() == 0) ev = 1'b0;
         if (q[i].size() == DEPTH) ef = 1'b1;
      end
      chk({tag, ".o_valid"}, {31'd0, o_valid}, {31'd0, ev});
      chk({tag, ".o_full"}, {31'd0, o_full}, {31'd0, ef});
      chk({tag, ".o_ready"}, {31'd0, o_ready}, {31'd0, ~ef});
      chk({tag, ".o_overflow"}, {31'd0, o_overflow}, {31'd0, ovf_m});
      if (ev) begin
         for (int i = 0; i < COL; i++) begin
            chk($sformatf("%s.out[%0d]", tag, i), {16'd0, out[W*i +: W]}, {16'd0, q[i][0]});
         end
      end
   endtask

   // One clock edge with the given inputs; the model follows the rules
   // (pop first when a full row exists, then pushes into lanes with room).
   task automatic step(input string tag, input logic [COL-1:0] w, input logic r,
                       input logic [W*COL-1:0] d);
      logic valid_m;
      logic pop_m;
      logic full_pre [COL];
      wr = w;
      rd = r;
      in = d;
      valid_m = 1'b1;
      for (int i = 0; i < COL; i++) begin
         if (q[i].size() == 0) valid_m = 1'b0;
         full_pre[i] = (q[i].size() == DEPTH);
      end
      pop_m = r && valid_m;
      if (pop_m) begin
         for (int i = 0; i < COL; i++) void'(q[i].pop_front());
      end
      for (int i = 0; i < COL; i++) begin
         if (w[i]) begin
            if (!full_pre[i] || pop_m) q[i].push_back(d[W*i +: W]);
            else ovf_m = 1'b1;
         end
      end
      @(posedge clk);
      #1;
      wr = '0;
      rd = 1'b0;
      check_all(tag);
   endtask

   // Asynchronous reset applied between edges; checked while still asserted.
   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #1;
      for (int i = 0; i < COL; i++) q[i].delete();
      ovf_m = 1'b0;
      check_all(tag);
      @(negedge clk);
      reset = 1'b0;
   endtask

   function automatic logic [W*COL-1:0] rnd_row();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   initial begin
      logic [W*COL-1:0] d;
      logic [W*COL-1:0] first_row;
      logic [COL-1:0]   w;
      total = 0;
      bad   = 0;
      ovf_m = 1'b0;
      wr    = '0;
      rd    = 1'b0;
      in    = '0;
      reset = 1'b1;
      #2;
      check_all("reset");
      @(negedge clk);
      reset = 1'b0;

      // Column-skewed fill: lane i pushes during cycles i..i+3 with data 16*i+k.
      for (int c = 0; c < COL + 3; c++) begin
         w = '0;
         d = '0;
         for (int i = 0; i < COL; i++) begin
            if (c >= i && c <= i + 3) begin
               w[i] = 1'b1;
               d[W*i +: W] = W'(16 * i + (c - i));
            end
         end
         step("skew_fill", w, 1'b0, d);
         if (c == COL - 2) chk("skew_not_yet_valid", {31'd0, o_valid}, 32'd0);
         if (c == COL - 1) chk("skew_valid_rise", {31'd0, o_valid}, 32'd1);
      end
      for (int k = 0; k < 4; k++) begin
         for (int i = 0; i < COL; i++) begin
            chk($sformatf("skew_row%0d_lane%0d", k, i), {16'd0, out[W*i +: W]}, 32'(16 * i + k));
         end
         step("skew_read", '0, 1'b1, '0);
      end
      chk("skew_drained", {31'd0, o_valid}, 32'd0);

      // Fill to full, then one extra push overflows; read everything back.
      do_reset("reset_full");
      for (int n = 0; n < DEPTH; n++) step("fill", '1, 1'b0, rnd_row());
      chk("full_flag", {31'd0, o_full}, 32'd1);
      chk("full_ready", {31'd0, o_ready}, 32'd0);
      step("overflow_push", '1, 1'b0, rnd_row());
      chk("overflow_set", {31'd0, o_overflow}, 32'd1);
      for (int n = 0; n < DEPTH; n++) step("drain", '0, 1'b1, '0);
      step("rd_empty", '0, 1'b1, '0);

      // Partial row: rd ignored until the last lane arrives.
      do_reset("reset_partial");
      step("partial_push", 8'h7f, 1'b0, rnd_row());
      step("partial_rd", '0, 1'b1, '0);
      chk("partial_no_valid", {31'd0, o_valid}, 32'd0);
      step("partial_lane7", 8'h80, 1'b0, rnd_row());
      step("partial_read", '0, 1'b1, '0);

      // Simultaneous push and pop on full lanes.
      do_reset("reset_pushpop");
      for (int n = 0; n < DEPTH; n++) step("fill2", '1, 1'b0, rnd_row());
      step("full_pushpop", '1, 1'b1, rnd_row());
      chk("pushpop_full", {31'd0, o_full}, 32'd1);
      chk("pushpop_no_ovf", {31'd0, o_overflow}, 32'd0);
      for (int n = 0; n < DEPTH; n++) step("drain2", '0, 1'b1, '0);

      // Streaming through pointer wrap.
      do_reset("reset_wrap");
      step("wrap_lead", '1, 1'b0, rnd_row());
      for (int n = 0; n < 200; n++) step("wrap", '1, 1'b1, rnd_row());

      // Random per-lane strobes and pops.
      do_reset("reset_rand");
      for (int n = 0; n < 400; n++) begin
         step("rand", COL'($urandom), 1'($urandom_range(0, 1)), rnd_row());
      end

      // Async reset with 10 rows stored and overflow already set.
      do_reset("reset_async_prep");
      for (int n = 0; n < DEPTH + 1; n++) step("fill3", '1, 1'b0, rnd_row());
      for (int n = 0; n < DEPTH - 10; n++) step("drain3", '0, 1'b1, '0);
      do_reset("async_reset");
      first_row = rnd_row();
      step("after_reset_push", '1, 1'b0, first_row);
      for (int i = 0; i < COL; i++) begin
         chk($sformatf("after_reset_lane%0d", i), {16'd0, out[W*i +: W]},
             {16'd0, first_row[W*i +: W]});
      end
      step("after_reset_read", '0, 1'b1, '0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ofifo.md
OFIFO -- requirements
Module: ofifo

Interface
- REQ-001: Parameter col, default 8, number of MAC columns and per-column FIFO lanes.
- REQ-002: Parameter psum_bw, default 16, partial-sum width per column.
- REQ-003: Parameter depth, default 64, entries per lane; power of two, at least 2.
- REQ-004: clk  input  1  single clock; all state updates on the rising edge.
- REQ-005: reset  input  1  asynchronous, active-high; clears all state immediately.
- REQ-006: in  input  psum_bw*col  column psums from the MAC row; lane i is in[psum_bw*(i+1)-1 : psum_bw*i].
- REQ-007: wr  input  col  per-lane push strobe, driven directly by the row's per-column valid.
- REQ-008: rd  input  1  pop request for one full output row.
- REQ-009: out  output  psum_bw*col  head entry of every lane, same lane packing as in.
- REQ-010: o_valid  output  1  all lanes non-empty, so out holds a complete row.
- REQ-011: o_full  output  1  at least one lane is full.
- REQ-012: o_ready  output  1  inverse of o_full.
- REQ-013: o_overflow  output  1  sticky flag: a push was dropped.

Function
- REQ-014: Each lane SHALL be an independent circular FIFO with a write pointer and a read pointer, each log2(depth)+1 bits wide.
- REQ-015: Lane empty SHALL mean wptr equals rptr; lane full SHALL mean the low bits are equal and the MSBs differ.
- REQ-016: On a clock edge with wr[i]=1 and lane i not full, lane i SHALL store its slice of in at wptr and increment wptr modulo 2*depth.
- REQ-017: On a clock edge with wr[i]=1 and lane i full, the push SHALL be dropped, lane i SHALL be left unchanged, and o_overflow SHALL be set to 1.
- REQ-018: o_overflow SHALL remain 1 until reset.
- REQ-019: Lanes SHALL fill independently; arbitrary wr patterns are legal, including the column-skewed pattern in which wr[i] asserts one cycle after wr[i-1].
- REQ-020: o_valid SHALL be combinational: the AND of all lanes' not-empty states.
- REQ-021: out SHALL be first-word-fall-through: each lane's head entry is driven combinationally, with no read latency.
- REQ-022: On a clock edge with rd=1 and o_valid=1, every lane SHALL increment rptr modulo 2*depth at the same time.
- REQ-023: rd=1 with o_valid=0 SHALL be ignored; no pointer moves and no error is flagged.
- REQ-024: When a push and a pop hit a full lane on the same edge, the pop SHALL be applied first, the push SHALL be accepted, the occupancy SHALL be unchanged, and no overflow is flagged.
- REQ-025: When a push and a pop hit a non-empty lane on the same edge, both SHALL take effect.
- REQ-026: A push into an empty lane SHALL NOT be poppable on the same edge; it becomes visible at out and o_valid on the cycle after the edge.
- REQ-027: Pointers SHALL wrap from 2*depth-1 to 0 without losing data order.
- REQ-028: o_full and o_ready SHALL be combinational from the pointers.

Reset
- REQ-029: While reset=1, all pointers SHALL be 0, o_valid=0, o_full=0, o_ready=1, and o_overflow=0, independent of clk.
- REQ-030: Storage contents SHALL NOT require reset, and out is don't-care while o_valid=0.
- REQ-031: Reset asserted mid-operation SHALL discard all stored rows; after release the block SHALL behave as freshly reset, and wr/rd SHALL take effect from the first rising edge after deassertion.

Verification
- REQ-032: Skewed fill: drive wr[i] high during cycles i..i+3 with lane i data 16*i+k, where k is the entry index 0..3. Required: o_valid rises the cycle after the lane-7 first push, then rd on four edges returns rows {16*i+k} for k=0..3, then o_valid=0.
- REQ-033: Fill to full: push 64 entries into all lanes with no rd. Required: o_full=1 and o_ready=0 after the 64th edge; a 65th push sets o_overflow=1, and the subsequent reads return entries 0..63 unchanged.
- REQ-034: Partial row: push only lanes 0..6, then pulse rd. Required: o_valid=0, no pointer change, and after pushing lane 7 the first row reads correctly.
- REQ-035: Simultaneous full push/pop: with all lanes full, assert wr=all-ones and rd=1 for 1 edge. Required: o_full stays 1, o_overflow stays 0, and the head advances by one row.
- REQ-036: Wrap: stream 200 rows with wr and rd both active each cycle after a 1-cycle lead. Required: every read row matches the written order, and o_full never asserts.
- REQ-037: Async reset: assert reset between clock edges while 10 rows are stored. Required: o_valid drops to 0 immediately, o_overflow=0, and after release the next pushed row is the first row read.
